// File: rtl/dense_pkg.sv
// Shared types and helpers for the dense-layer sequencer.
`default_nettype none

package dense_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    MAC   = 3'd2,
    BIAS  = 3'd3,
    FLUSH = 3'd4,
    WRITE = 3'd5,
    DONE  = 3'd6
  } state_t;

  // Cycles spent per output neuron: CLEAR + IN_COUNT MAC + BIAS + FLUSH + WRITE.
  function automatic int cyc_per_neuron(input int in_count);
    return in_count + 4;
  endfunction

  // Address width that stays at least one bit for single-entry memories.
  function automatic int adr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod_counter.sv
// Modulo-MAX counter with synchronous clear, enable and terminal-count flag.
`default_nettype none

module mod_counter
  import dense_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      en,
  output logic [adr_width(MAX)-1:0] count,
  output logic                      tc
);

  localparam int W = adr_width(MAX);

  assign tc = (count == W'(MAX - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/dense_sequencer.sv
// Sequences one fully-connected layer on the dense MAC datapath, issuing
// buffer/LUT addresses and accumulate strobes aligned to 1-cycle read latency.
`default_nettype none

module dense_sequencer
  import dense_pkg::*;
#(
  parameter int IN_COUNT  = 784,
  parameter int OUT_COUNT = 10
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  output logic                                      busy,
  output logic                                      done,
  output logic [adr_width(IN_COUNT)-1:0]            inAdr,
  output logic [adr_width(IN_COUNT*OUT_COUNT)-1:0]  weightAdr,
  output logic [adr_width(OUT_COUNT)-1:0]           biasAdr,
  output logic [adr_width(OUT_COUNT)-1:0]           outAdr,
  output logic                                      accClear,
  output logic                                      accEn,
  output logic                                      accSelBias,
  output logic                                      outWr
);

  localparam int IN_W  = adr_width(IN_COUNT);
  localparam int WT_W  = adr_width(IN_COUNT * OUT_COUNT);
  localparam int OUT_W = adr_width(OUT_COUNT);

  state_t            state;
  state_t            state_nxt;
  logic [IN_W-1:0]   in_cnt;
  logic [OUT_W-1:0]  out_cnt;
  logic [WT_W-1:0]   weight_adr;
  logic              in_last;
  logic              out_last;
  logic              acc_en;
  logic              acc_sel_bias;

  mod_counter #(.MAX(IN_COUNT)) u_in_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (state == CLEAR),
    .en    (state == MAC),
    .count (in_cnt),
    .tc    (in_last)
  );

  mod_counter #(.MAX(OUT_COUNT)) u_out_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (state == IDLE),
    .en    (state == WRITE),
    .count (out_cnt),
    .tc    (out_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Running weight address: equals out_cnt*IN_COUNT + in_cnt without a multiplier.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      weight_adr <= '0;
    end else if (state == IDLE && start) begin
      weight_adr <= '0;
    end else if (state == MAC) begin
      weight_adr <= weight_adr + WT_W'(1);
    end
  end

  // Operands arrive one cycle after their address, so the strobes lag the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_en       <= 1'b0;
      acc_sel_bias <= 1'b0;
    end else begin
      acc_en       <= (state == MAC) || (state == BIAS);
      acc_sel_bias <= (state == BIAS);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CLEAR;
      CLEAR:   state_nxt = MAC;
      MAC:     if (in_last) state_nxt = BIAS;
      BIAS:    state_nxt = FLUSH;
      FLUSH:   state_nxt = WRITE;
      WRITE:   state_nxt = out_last ? DONE : CLEAR;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign accClear   = (state == CLEAR);
  assign outWr      = (state == WRITE);
  assign accEn      = acc_en;
  assign accSelBias = acc_sel_bias;
  assign inAdr      = in_cnt;
  assign weightAdr  = weight_adr;
  assign biasAdr    = out_cnt;
  assign outAdr     = out_cnt;

endmodule

`default_nettype wire

// File: tb/tb_dense_sequencer.sv
// Self-checking bench: timing model of the layer schedule plus a 1-cycle-latency memory/accumulator model.
`default_nettype none

module tb_dense_sequencer;

  localparam int NI = 4;
  localparam int NO = 3;
  localparam int LAST = NO * (NI + 4) + 1;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic start_c;

  logic       busy, done, accClear, accEn, accSelBias, outWr;
  logic [1:0] inAdr;
  logic [3:0] weightAdr;
  logic [1:0] biasAdr, outAdr;

  logic       c1_busy, c1_done, c1_clr, c1_en, c1_sel, c1_wr;
  logic       c1_in, c1_wt, c1_bias, c1_out;
  logic       c2_busy, c2_done, c2_clr, c2_en, c2_sel, c2_wr;
  logic       c2_in;
  logic [1:0] c2_wt, c2_bias, c2_out;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  int in_mem [0:3];
  int w_mem  [0:15];
  int b_mem  [0:3];
  int acc, in_d, w_d, b_d;
  logic p_clr, p_en, p_sel;
  logic [1:0] p_in, p_b;
  logic [3:0] p_w;

  int done_cnt, done_first, done_second;

  always #5 clk = ~clk;

  dense_sequencer #(.IN_COUNT(NI), .OUT_COUNT(NO)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .inAdr(inAdr), .weightAdr(weightAdr), .biasAdr(biasAdr), .outAdr(outAdr),
    .accClear(accClear), .accEn(accEn), .accSelBias(accSelBias), .outWr(outWr)
  );

  dense_sequencer #(.IN_COUNT(1), .OUT_COUNT(1)) dut_c1 (
    .clk(clk), .rst(rst), .start(start_c), .busy(c1_busy), .done(c1_done),
    .inAdr(c1_in), .weightAdr(c1_wt), .biasAdr(c1_bias), .outAdr(c1_out),
    .accClear(c1_clr), .accEn(c1_en), .accSelBias(c1_sel), .outWr(c1_wr)
  );

  dense_sequencer #(.IN_COUNT(1), .OUT_COUNT(4)) dut_c2 (
    .clk(clk), .rst(rst), .start(start_c), .busy(c2_busy), .done(c2_done),
    .inAdr(c2_in), .weightAdr(c2_wt), .biasAdr(c2_bias), .outAdr(c2_out),
    .accClear(c2_clr), .accEn(c2_en), .accSelBias(c2_sel), .outWr(c2_wr)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s at %0t: observed=%0h expected=%0h", name, $time, obs, exp);
    end
  endtask

  // Expected {busy,done,accClear,accEn,accSelBias,outWr} in cycle r after the start edge.
  function automatic logic [5:0] exp_ctrl(input int r, input int n_in, input int n_out);
    int cyc, last, pos;
    logic b, d, c, e, s, w;
    cyc  = n_in + 4;
    last = n_out * cyc + 1;
    b = (r >= 1) && (r <= last);
    d = (r == last);
    c = 1'b0; e = 1'b0; s = 1'b0; w = 1'b0;
    if (r >= 1 && r < last) begin
      pos = (r - 1) % cyc;
      c = (pos == 0);
      e = (pos >= 2) && (pos <= n_in + 2);
      s = (pos == n_in + 2);
      w = (pos == cyc - 1);
    end
    return {b, d, c, e, s, w};
  endfunction

  function automatic int exp_sum(input int j);
    int s;
    s = b_mem[j];
    for (int i = 0; i < NI; i++) s += in_mem[i] * w_mem[j * NI + i];
    return s;
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 4; i++) in_mem[i] = int'($urandom_range(0, 255));
    for (int i = 0; i < 16; i++) w_mem[i] = int'($urandom_range(0, 255));
    for (int i = 0; i < 4; i++) b_mem[i] = int'($urandom_range(0, 1023));
  endtask

  // Advance one cycle; the memories and the accumulator act on the cycle just ended.
  task automatic tick();
    @(posedge clk);
    #1;
    if (p_clr) acc = 0;
    else if (p_en) acc += p_sel ? b_d : in_d * w_d;
    in_d = in_mem[p_in];
    w_d  = w_mem[p_w];
    b_d  = b_mem[p_b];
    p_clr = accClear; p_en = accEn; p_sel = accSelBias;
    p_in = inAdr; p_w = weightAdr; p_b = biasAdr;
  endtask

  task automatic check_main(input int r);
    int pos, j;
    check("ctrl", {busy, done, accClear, accEn, accSelBias, outWr}, exp_ctrl(r, NI, NO));
    if (r >= 1 && r < LAST) begin
      pos = (r - 1) % (NI + 4);
      j   = (r - 1) / (NI + 4);
      if (pos >= 1 && pos <= NI) begin
        check("inAdr", inAdr, pos - 1);
        check("weightAdr", weightAdr, j * NI + pos - 1);
      end
      if (pos == NI + 1) check("biasAdr", biasAdr, j);
      if (pos == NI + 3) begin
        check("outAdr", outAdr, j);
        check("acc_sum", acc, exp_sum(j));
      end
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; start_c = 1'b0;
    acc = 0; in_d = 0; w_d = 0; b_d = 0;
    p_clr = 0; p_en = 0; p_sel = 0; p_in = 0; p_w = 0; p_b = 0;
    fill_mem();

    // Reset state
    #2;
    check("reset_main", {busy, done, accClear, accEn, accSelBias, outWr, inAdr, weightAdr, biasAdr, outAdr}, 0);
    check("reset_corner", {c1_busy, c1_done, c1_clr, c1_en, c1_sel, c1_wr, c1_in, c1_wt, c1_bias, c1_out,
                           c2_busy, c2_done, c2_clr, c2_en, c2_sel, c2_wr, c2_in, c2_wt, c2_bias, c2_out}, 0);
    tick(); tick();
    #2 rst = 1'b1;
    repeat (int'($urandom_range(1, 5))) tick();
    check("idle_after_reset", {busy, done, outWr}, 0);

    // Single layer, start pulse
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 1; r <= LAST + 1; r++) begin
      check_main(r);
      tick();
    end

    // Start held high: one layer, IDLE for one cycle, then a second layer
    fill_mem();
    done_cnt = 0; done_first = 0; done_second = 0;
    start = 1'b1;
    tick();
    for (int r = 1; r <= 60; r++) begin
      check_main((r <= LAST + 1) ? r : r - (LAST + 1));
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) done_first = r;
        else done_second = r;
      end
      if (r == 30) start = 1'b0;
      tick();
    end
    check("held_done_count", done_cnt, 2);
    check("held_done_gap", done_second - done_first, LAST + 1);

    // Reset asserted during MAC of neuron 1
    fill_mem();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 1; r <= NI + 7; r++) begin
      check_main(r);
      if (r < NI + 7) tick();
    end
    #3 rst = 1'b0;
    #1;
    check("async_reset_out", {busy, done, accClear, accEn, accSelBias, outWr, inAdr, weightAdr, biasAdr, outAdr}, 0);
    for (int r = 0; r < 3; r++) begin
      tick();
      check("in_reset_ctrl", {busy, done, accClear, accEn, accSelBias, outWr}, 0);
    end
    #2 rst = 1'b1;
    for (int r = 0; r < 5; r++) begin
      tick();
      check("post_reset_quiet", {busy, done, outWr}, 0);
    end
    fill_mem();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 1; r <= LAST + 1; r++) begin
      check_main(r);
      tick();
    end

    // Corner configurations IN=1/OUT=1 and IN=1/OUT=4
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    for (int r = 1; r <= 25; r++) begin
      check("c1_ctrl", {c1_busy, c1_done, c1_clr, c1_en, c1_sel, c1_wr}, exp_ctrl(r, 1, 1));
      check("c2_ctrl", {c2_busy, c2_done, c2_clr, c2_en, c2_sel, c2_wr}, exp_ctrl(r, 1, 4));
      if (r % 5 == 0 && r <= 20) check("c2_outAdr", c2_out, (r - 1) / 5);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
